// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams operand pairs from two sync-read memories
// into one MAC instance, drains its pipeline and hands the result to a consumer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a command; cmd_ready=1, MAC held (sload=1, ce=0)
// S_FEED  | issuing L reads, one pair per cycle, address = base + cnt
// S_DRAIN | waiting for dv/lag pipe to empty, then DRAIN_CYC settle cycles
// S_DONE  | result presented on res_valid/res_data until handshake
module mac_dot_seq #(
  parameter int N         = 16,
  parameter int AW        = 8,
  parameter int LEN_W     = 8,
  parameter int SLOAD_LAG = 1,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [AW-1:0]    cmd_base_a,
  input  logic [AW-1:0]    cmd_base_b,
  output logic             mem_rd,
  output logic [AW-1:0]    mem_a_addr,
  output logic [AW-1:0]    mem_b_addr,
  input  logic [N-1:0]     mem_a_data,
  input  logic [N-1:0]     mem_b_data,
  output logic             mac_ce,
  output logic             mac_sload,
  output logic [N-1:0]     mac_a,
  output logic [N-1:0]     mac_b,
  input  logic [N-1:0]     mac_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic             busy
);

  localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [AW-1:0]        base_a_q, base_a_d;
  logic [AW-1:0]        base_b_q, base_b_d;
  logic [DC_W-1:0]      dcnt_q, dcnt_d;
  logic                 mac_ce_q, mac_ce_d;
  logic                 res_valid_q, res_valid_d;
  logic [N-1:0]         res_data_q, res_data_d;
  logic                 dv_q, dv_d;
  logic [SLOAD_LAG-1:0] lag_q, lag_d;
  logic                 pipe_empty;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      base_a_q    <= '0;
      base_b_q    <= '0;
      dcnt_q      <= '0;
      mac_ce_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      dv_q        <= 1'b0;
      lag_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_a_q    <= base_a_d;
      base_b_q    <= base_b_d;
      dcnt_q      <= dcnt_d;
      mac_ce_q    <= mac_ce_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      dv_q        <= dv_d;
      lag_q       <= lag_d;
    end
  end

  // Read data arrives one cycle after mem_rd; sload trails it by SLOAD_LAG.
  always_comb begin
    dv_d     = mem_rd;
    lag_d    = '0;
    lag_d[0] = dv_q;
    for (int i = 1; i < SLOAD_LAG; i++) begin
      lag_d[i] = lag_q[i-1];
    end
  end

  assign pipe_empty = !dv_q && (lag_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_a_d    = base_a_q;
    base_b_d    = base_b_q;
    dcnt_d      = dcnt_q;
    mac_ce_d    = mac_ce_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          len_d    = cmd_len;
          base_a_d = cmd_base_a;
          base_b_d = cmd_base_b;
          cnt_d    = '0;
          if (cmd_len != '0) begin
            state_d  = S_FEED;
            mac_ce_d = 1'b1;
          end else begin
            // Empty vector: result is zero and the MAC is left untouched.
            state_d    = S_DONE;
            res_data_d = '0;
          end
        end
      end

      S_FEED: begin
        cnt_d = cnt_q + LEN_W'(1);
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = S_DRAIN;
          dcnt_d  = DC_W'(DRAIN_CYC - 1);
        end
      end

      S_DRAIN: begin
        if (pipe_empty) begin
          if (dcnt_q == '0) begin
            res_data_d  = mac_p;
            res_valid_d = 1'b1;
            mac_ce_d    = 1'b0;
            state_d     = S_DONE;
          end else begin
            dcnt_d = dcnt_q - DC_W'(1);
          end
        end
      end

      S_DONE: begin
        // The L=0 path arrives here with res_valid still low; raise it first.
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign mem_rd     = (state_q == S_FEED);
  assign mem_a_addr = base_a_q + AW'(cnt_q);
  assign mem_b_addr = base_b_q + AW'(cnt_q);
  assign mac_ce     = mac_ce_q;
  assign mac_sload  = ~lag_q[SLOAD_LAG-1];
  assign mac_a      = dv_q ? mem_a_data : '0;
  assign mac_b      = dv_q ? mem_b_data : '0;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with behavioural sync-read memories and a
// MAC model whose first accumulate after a sload=1 run loads instead of adds.
module tb_mac_dot_seq;

  logic        clk = 1'b0;
  logic        arst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_len;
  logic [7:0]  cmd_base_a;
  logic [7:0]  cmd_base_b;
  logic        mem_rd;
  logic [7:0]  mem_a_addr;
  logic [7:0]  mem_b_addr;
  logic [15:0] mem_a_data;
  logic [15:0] mem_b_data;
  logic        mac_ce;
  logic        mac_sload;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [15:0] mac_p;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        busy;

  mac_dot_seq dut (
    .clk        (clk),
    .arst       (arst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_base_a (cmd_base_a),
    .cmd_base_b (cmd_base_b),
    .mem_rd     (mem_rd),
    .mem_a_addr (mem_a_addr),
    .mem_b_addr (mem_b_addr),
    .mem_a_data (mem_a_data),
    .mem_b_data (mem_b_data),
    .mac_ce     (mac_ce),
    .mac_sload  (mac_sload),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_p      (mac_p),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_a_data <= mem_a[mem_a_addr];
      mem_b_data <= mem_b[mem_b_addr];
    end else begin
      mem_a_data <= 16'hBAD1;
      mem_b_data <= 16'hBAD2;
    end
  end

  // MAC model: one input register stage (SLOAD_LAG=1), accumulator, output register.
  logic signed [15:0] a_r, b_r, acc, p_r;
  logic               sl_r;
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      a_r  <= '0;
      b_r  <= '0;
      acc  <= '0;
      p_r  <= '0;
      sl_r <= 1'b1;
    end else if (mac_ce) begin
      a_r  <= mac_a;
      b_r  <= mac_b;
      sl_r <= mac_sload;
      if (!mac_sload) acc <= (sl_r ? 16'sd0 : acc) + a_r * b_r;
      p_r  <= acc;
    end
  end
  assign mac_p = p_r;

  // Cumulative activity counters; tests take differences around each command.
  int          n_sl0  = 0;
  int          n_fall = 0;
  int          n_ce   = 0;
  logic        sl_prev = 1'b1;
  logic [7:0]  addr_log[$];

  always @(negedge clk) begin
    if (!mac_sload) n_sl0++;
    if (sl_prev && !mac_sload) n_fall++;
    sl_prev = mac_sload;
    if (mac_ce) n_ce++;
    if (mem_rd) addr_log.push_back(mem_a_addr);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int sl0_base, fall_base, ce_base, addr_base;

  task automatic run_cmd(input logic [7:0] len, input logic [7:0] ba, input logic [7:0] bb,
                         output int lat);
    @(negedge clk);
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_len    = len;
    cmd_base_a = ba;
    cmd_base_b = bb;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    sl0_base  = n_sl0;
    fall_base = n_fall;
    ce_base   = n_ce;
    addr_base = addr_log.size();
    lat = 0;
    while (!res_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("hs_res_valid_low", res_valid, 0);
    chk("hs_busy_low", busy, 0);
  endtask

  int lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'h0;
      mem_b[i] = 16'h0;
    end
    mem_a[8'h10] = 16'd1;  mem_a[8'h11] = 16'd2;  mem_a[8'h12] = 16'd3;  mem_a[8'h13] = 16'd4;
    mem_b[8'h20] = 16'd5;  mem_b[8'h21] = 16'd6;  mem_b[8'h22] = 16'd7;  mem_b[8'h23] = 16'd8;
    mem_a[8'hFE] = 16'd2;  mem_a[8'hFF] = 16'hFFFD; mem_a[8'h00] = 16'd4; mem_a[8'h01] = 16'd1;
    mem_b[8'h40] = 16'd10; mem_b[8'h41] = 16'd10;   mem_b[8'h42] = 16'hFFFE; mem_b[8'h43] = 16'd7;
    mem_a[8'h80] = 16'd3;  mem_b[8'h90] = 16'hFFFE;
    mem_a[8'h81] = 16'hFFFF; mem_b[8'h91] = 16'hFFFF;
    mem_a[8'h82] = 16'd2;  mem_b[8'h92] = 16'd2;

    arst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_base_a = '0; cmd_base_b = '0;
    res_ready = 1'b0;
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sload", mac_sload, 1);
    chk("rst_ce", mac_ce, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_mem_rd", mem_rd, 0);
    @(negedge clk);
    arst = 1'b0;

    // L=4 basic dot product: 1*5+2*6+3*7+4*8
    run_cmd(8'd4, 8'h10, 8'h20, lat);
    chk("t2_latency", lat, 9);
    chk("t2_res_data", res_data, 16'd70);
    chk("t2_sload0_cycles", n_sl0 - sl0_base, 4);
    chk("t2_sload0_runs", n_fall - fall_base, 1);
    chk("t2_ce_cycles", n_ce - ce_base, 9);
    chk("t2_reads", addr_log.size() - addr_base, 4);
    handshake();

    // L=0: immediate zero result, MAC never enabled
    run_cmd(8'd0, 8'h10, 8'h20, lat);
    chk("t3_latency", lat, 1);
    chk("t3_res_data", res_data, 16'd0);
    chk("t3_ce_cycles", n_ce - ce_base, 0);
    chk("t3_reads", addr_log.size() - addr_base, 0);
    handshake();

    // Address wrap on the A side: FE,FF,00,01 -> 20-30-8+7 = -11
    run_cmd(8'd4, 8'hFE, 8'h40, lat);
    chk("t4_latency", lat, 9);
    chk("t4_res_data", res_data, 16'hFFF5);
    chk("t4_reads", addr_log.size() - addr_base, 4);
    if (addr_log.size() - addr_base == 4) begin
      chk("t4_addr0", addr_log[addr_base],     8'hFE);
      chk("t4_addr1", addr_log[addr_base + 1], 8'hFF);
      chk("t4_addr2", addr_log[addr_base + 2], 8'h00);
      chk("t4_addr3", addr_log[addr_base + 3], 8'h01);
    end
    handshake();

    // Backpressure and cmd_valid while busy: L=3 -> 38, with a pending L=0 command held high
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = 8'd3; cmd_base_a = 8'h10; cmd_base_b = 8'h20;
    @(posedge clk);
    #1;
    cmd_len = 8'd0;
    lat = 0;
    while (!res_valid && lat < 200) begin
      @(negedge clk);
      if (lat == 2) chk("t5_cmd_ready_busy", cmd_ready, 0);
      lat++;
    end
    chk("t5_latency_bound", (lat < 200), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", res_valid, 1);
      chk("t5_hold_data", res_data, 16'd38);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("t5_idle_after_hs", busy, 0);
    chk("t5_cmd_ready_after_hs", cmd_ready, 1);
    @(posedge clk);
    #1;
    chk("t5_accept_in_idle", busy, 1);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_l0_valid", res_valid, 1);
    chk("t5_l0_data", res_data, 16'd0);
    handshake();

    // Back-to-back: 3*-2 = -6, then -1*-1 + 2*2 = 5
    run_cmd(8'd1, 8'h80, 8'h90, lat);
    chk("t6a_latency", lat, 6);
    chk("t6a_res_data", res_data, 16'hFFFA);
    handshake();
    run_cmd(8'd2, 8'h81, 8'h91, lat);
    chk("t6b_latency", lat, 7);
    chk("t6b_res_data", res_data, 16'd5);
    chk("t6b_sload0_cycles", n_sl0 - sl0_base, 2);
    handshake();

    // Reset mid-FEED aborts at once
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = 8'd4; cmd_base_a = 8'h10; cmd_base_b = 8'h20;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t1_in_feed", mem_rd, 1);
    #2;
    arst = 1'b1;
    #1;
    chk("t1_sload_async", mac_sload, 1);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_cmd_ready", cmd_ready, 1);
    chk("t1_sload", mac_sload, 1);
    chk("t1_ce", mac_ce, 0);
    chk("t1_res_valid", res_valid, 0);

    // Recovery run after the abort
    run_cmd(8'd4, 8'h10, 8'h20, lat);
    chk("t1_rerun_latency", lat, 9);
    chk("t1_rerun_data", res_data, 16'd70);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
